wb_stage: RTL

- MEM/WB pipeline register plus writeback logic for the 5-stage MIPS pipeline.
- It is the writer side of the register file: it produces the write-enable, destination index and write data that the register file samples on the rising edge.
- Destination select (rd/rt) and memory-vs-ALU data select happen here, so the register file's write path sees a single destination and a single data word.
- It also raises same-cycle bypass hits for the ID stage, because register file reads are combinational and would otherwise return the pre-write value.
- It keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 73 +++++++
 1 files changed

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback path for the 5-stage MIPS pipeline.
// Drives the register-file write port, same-cycle ID bypass hits and a retired-instruction counter.
module wb_stage #(
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned ADDR_W            = 5,
  parameter int unsigned CNT_W             = 16,
  parameter bit          ZERO_REG_WRITABLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_reg_dst,
  input  logic              in_mem_to_reg,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic              wb_reg_write,
  output logic [ADDR_W-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_count
);

  logic              v_q;
  logic              rw_q;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              zero_blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      rw_q   <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      // The instruction already in WB retires even when a flush squashes the incoming one.
      if (v_q && !stall) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flush) begin
        v_q <= 1'b0;
      end else if (!stall) begin
        v_q    <= in_valid;
        rw_q   <= in_reg_write;
        dest_q <= in_reg_dst ? in_rd : in_rt;
        data_q <= in_mem_to_reg ? in_mem_data : in_alu_result;
      end
    end
  end

  always_comb begin
    zero_blocked  = (ZERO_REG_WRITABLE == 1'b0) && (dest_q == '0);
    wb_reg_write  = v_q && rw_q && !zero_blocked;
    wb_write_reg  = dest_q;
    wb_write_data = data_q;
    fwd_data      = data_q;
    fwd_rs_hit    = wb_reg_write && (id_rs == dest_q);
    fwd_rt_hit    = wb_reg_write && (id_rt == dest_q);
    retired_count = cnt_q;
  end

endmodule
